// File: rtl/ifstmt_sink_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : ifstmt_pkg                                                |
// | Purpose  : Shared class codes and FSM state encodings for the        |
// |            ifstmt_sink word classifier.                              |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package ifstmt_pkg;

  // Classification codes reported on rep_class
  localparam logic [1:0] CLS_OTHER = 2'd0;
  localparam logic [1:0] CLS_ONE   = 2'd1;
  localparam logic [1:0] CLS_TWO   = 2'd2;
  localparam logic [1:0] CLS_SEQ   = 2'd3;

  // Number of classes, one saturating counter each
  localparam int NUM_CLASSES = 4;

  // FSM state encodings
  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_EVAL   = 2'd1;
  localparam logic [STATE_W-1:0] ST_REPORT = 2'd2;

endpackage
`default_nettype wire

// File: rtl/ifstmt_sink_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : sat_counter                                               |
// | Purpose  : Up-counter that sticks at its all-ones maximum; a         |
// |            synchronous clear takes priority over an increment.       |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] C_MAX = '1;

  logic [CNT_WIDTH-1:0] r_count;

  // Count up on inc, hold at maximum, clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != C_MAX)) begin
      r_count <= r_count + CNT_WIDTH'(1);
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ifstmt_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ifstmt_sink                                               |
// | Purpose  : Valid/ready word sink. Each accepted word is classified   |
// |            as one, two, seq (a one following a two) or other,        |
// |            counted in a saturating per-class counter and reported    |
// |            with a one-cycle rep_valid pulse.                         |
// | Options  : IFSTMT_SINK_DISPLAY_EN - simulation trace of each report  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module ifstmt_sink
  import ifstmt_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 clear,
  output logic                 rep_valid,
  output logic [1:0]           rep_class,
  output logic [WIDTH-1:0]     rep_data,
  output logic [CNT_WIDTH-1:0] one_cnt,
  output logic [CNT_WIDTH-1:0] two_cnt,
  output logic [CNT_WIDTH-1:0] seq_cnt,
  output logic [CNT_WIDTH-1:0] other_cnt
);

  localparam logic [WIDTH-1:0] C_WORD_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] C_WORD_TWO = WIDTH'(2);

  logic [STATE_W-1:0]   r_state;
  logic [STATE_W-1:0]   w_state_nxt;
  logic [WIDTH-1:0]     r_word;
  logic [WIDTH-1:0]     r_rep_data;
  logic [1:0]           r_rep_class;
  logic                 r_prev_two;
  logic [1:0]           w_class;
  logic                 w_accept;
  logic                 w_eval;
  logic [CNT_WIDTH-1:0] w_cnt [NUM_CLASSES];

  // in_ready is a pure decode of the state register, so acceptance
  // never depends combinationally on in_valid
  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_eval   = (r_state == ST_EVAL);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: IDLE -> EVAL on accept, EVAL -> REPORT -> IDLE unconditionally
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_EVAL;
      ST_EVAL:   w_state_nxt = ST_REPORT;
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Moore outputs decoded from the current state
  always_comb begin
    in_ready  = 1'b0;
    rep_valid = 1'b0;
    case (r_state)
      ST_IDLE:   in_ready  = 1'b1;
      ST_REPORT: rep_valid = 1'b1;
      default:   ;
    endcase
  end

  // Nested classification of the latched word against the history bit
  always_comb begin
    w_class = CLS_OTHER;
    if (r_word == C_WORD_ONE) begin
      if (r_prev_two) begin
        w_class = CLS_SEQ;
      end else begin
        w_class = CLS_ONE;
      end
    end else if (r_word == C_WORD_TWO) begin
      w_class = CLS_TWO;
    end else begin
      w_class = CLS_OTHER;
    end
  end

  // Capture the incoming word on acceptance; clear does not touch it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
    end else if (w_accept) begin
      r_word <= in_data;
    end
  end

  // Report registers and history: clear overrides the EVAL update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep_class <= CLS_OTHER;
      r_rep_data  <= '0;
      r_prev_two  <= 1'b0;
    end else if (clear) begin
      r_rep_class <= CLS_OTHER;
      r_rep_data  <= '0;
      r_prev_two  <= 1'b0;
    end else if (w_eval) begin
      r_rep_class <= w_class;
      r_rep_data  <= r_word;
      r_prev_two  <= (r_word == C_WORD_TWO);
    end
  end

  assign rep_class = r_rep_class;
  assign rep_data  = r_rep_data;

  // One saturating counter per class, indexed by class code
  for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cnt
    sat_counter #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_eval && (w_class == 2'(gi))),
      .clr   (clear),
      .count (w_cnt[gi])
    );
  end

  assign other_cnt = w_cnt[CLS_OTHER];
  assign one_cnt   = w_cnt[CLS_ONE];
  assign two_cnt   = w_cnt[CLS_TWO];
  assign seq_cnt   = w_cnt[CLS_SEQ];

`ifdef IFSTMT_SINK_DISPLAY_EN
  // Simulation trace of every classification report
  always_ff @(posedge clk) begin
    if (r_state == ST_REPORT) begin
      $display("ifstmt_sink report: class=%0d data=%h", r_rep_class, r_rep_data);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifstmt_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_ifstmt_sink                                            |
// | Purpose  : Self-checking bench for ifstmt_sink with a reference      |
// |            classifier and a scoreboard of expected reports.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_ifstmt_sink;
  import ifstmt_pkg::*;

  localparam int W   = 32;
  localparam int CW  = 16;
  localparam int CWB = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (default counter width)
  logic          in_valid = 1'b0, in_ready, clear = 1'b0, rep_valid;
  logic [W-1:0]  in_data = '0, rep_data;
  logic [1:0]    rep_class;
  logic [CW-1:0] one_cnt, two_cnt, seq_cnt, other_cnt;

  // Narrow-counter DUT for saturation
  logic           b_in_valid = 1'b0, b_in_ready, b_clear = 1'b0, b_rep_valid;
  logic [W-1:0]   b_in_data = '0, b_rep_data;
  logic [1:0]     b_rep_class;
  logic [CWB-1:0] b_one_cnt, b_two_cnt, b_seq_cnt, b_other_cnt;

  ifstmt_sink #(.WIDTH(W), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .clear(clear), .rep_valid(rep_valid),
    .rep_class(rep_class), .rep_data(rep_data), .one_cnt(one_cnt),
    .two_cnt(two_cnt), .seq_cnt(seq_cnt), .other_cnt(other_cnt)
  );

  ifstmt_sink #(.WIDTH(W), .CNT_WIDTH(CWB)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .clear(b_clear), .rep_valid(b_rep_valid),
    .rep_class(b_rep_class), .rep_data(b_rep_data), .one_cnt(b_one_cnt),
    .two_cnt(b_two_cnt), .seq_cnt(b_seq_cnt), .other_cnt(b_other_cnt)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_count = 0;
  int rep_count = 0;

  typedef struct {
    logic [1:0] cls;
    logic [W-1:0] data;
    int acc;
    bit cnt;
  } exp_t;

  exp_t sb[$];
  logic m_prev_two = 1'b0;
  int unsigned m_cnt [4] = '{0, 0, 0, 0};

  always @(posedge clk) cyc++;

  // Reset empties the scoreboard and the reference model
  always @(negedge rst_n) begin
    sb.delete();
    m_prev_two = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  end

  // Scoreboard monitor: pop and compare on reports, then apply clear, then push on acceptance
  always @(negedge clk) begin
    if (rst_n) begin
      if (rep_valid) begin
        rep_count++;
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL report_unexpected: got class=%0d data=%h with nothing pending", rep_class, rep_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          // rep_* become valid at the first edge after the acceptance edge
          if (rep_class !== e.cls || rep_data !== e.data || (cyc - e.acc) != 1) begin
            bad++;
            $display("FAIL report: got class=%0d data=%h lat=%0d, want class=%0d data=%h lat=1",
                     rep_class, rep_data, cyc - e.acc, e.cls, e.data);
          end
          if (e.cnt && m_cnt[e.cls] < CMAX) m_cnt[e.cls]++;
        end
      end
      if (clear) begin
        m_prev_two = 1'b0;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        if (sb.size() != 0 && sb[$].acc == cyc) begin
          exp_t t;
          t = sb.pop_back();
          t.cls = CLS_OTHER;
          t.data = '0;
          t.cnt = 1'b0;
          sb.push_back(t);
        end
      end
      if (in_valid && in_ready) begin
        exp_t n;
        n.data = in_data;
        n.acc = cyc + 1;
        n.cnt = 1'b1;
        if (in_data == 32'd1) n.cls = m_prev_two ? CLS_SEQ : CLS_ONE;
        else if (in_data == 32'd2) n.cls = CLS_TWO;
        else n.cls = CLS_OTHER;
        m_prev_two = (in_data == 32'd2);
        sb.push_back(n);
        acc_count++;
      end
    end
  end

  task automatic send(input logic [W-1:0] w);
    int n = 0;
    in_data = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: pending=%0d, want 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || rep_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_handshake: in_ready=%b rep_valid=%b, want 1 0", in_ready, rep_valid);
    end
    total++;
    if ({one_cnt, two_cnt, seq_cnt, other_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_counts: %0d %0d %0d %0d, want 0 0 0 0", one_cnt, two_cnt, seq_cnt, other_cnt);
    end
    total++;
    if (rep_class !== 2'd0 || rep_data !== '0) begin
      bad++;
      $display("FAIL reset_report: class=%0d data=%h, want 0 0", rep_class, rep_data);
    end
    total++;
    if (b_in_ready !== 1'b1 || {b_one_cnt, b_two_cnt, b_seq_cnt, b_other_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_sat_dut: in_ready=%b counts=%h, want 1 0", b_in_ready,
               {b_one_cnt, b_two_cnt, b_seq_cnt, b_other_cnt});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int rc0 = rep_count;
    send(32'd1);
    send(32'd2);
    send(32'd1);
    send(32'd5);
    drain();
    total++;
    if (rep_count - rc0 != 4) begin
      bad++;
      $display("FAIL b2b_reports: got %0d pulses, want 4", rep_count - rc0);
    end
    total++;
    if (one_cnt !== 16'd1 || two_cnt !== 16'd1 || seq_cnt !== 16'd1 || other_cnt !== 16'd1) begin
      bad++;
      $display("FAIL b2b_counts: %0d %0d %0d %0d, want 1 1 1 1", one_cnt, two_cnt, seq_cnt, other_cnt);
    end
  endtask

  task automatic test_hold_valid();
    int ac0 = acc_count;
    in_data = 32'd7;
    in_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_valid = 1'b0;
    in_data = '0;
    drain();
    total++;
    if (acc_count - ac0 != 4) begin
      bad++;
      $display("FAIL hold_accepts: got %0d, want 4", acc_count - ac0);
    end
    total++;
    if (other_cnt !== 16'd5 || other_cnt !== CW'(m_cnt[CLS_OTHER])) begin
      bad++;
      $display("FAIL hold_other_cnt: got %0d, want 5", other_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 7; i++) begin
      logic [1:0] want;
      int n;
      want = (i < 6) ? CLS_TWO : CLS_SEQ;
      b_in_data = (i < 6) ? 32'd2 : 32'd1;
      b_in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!b_in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!b_rep_valid && n < 10) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (b_rep_valid !== 1'b1 || b_rep_class !== want) begin
        bad++;
        $display("FAIL sat_class[%0d]: valid=%b class=%0d, want 1 %0d", i, b_rep_valid, b_rep_class, want);
      end
      @(posedge clk); #1;
    end
    total++;
    if (b_two_cnt !== 2'd3 || b_seq_cnt !== 2'd1) begin
      bad++;
      $display("FAIL sat_counts: two=%0d seq=%0d, want 3 1", b_two_cnt, b_seq_cnt);
    end
    total++;
    if (b_one_cnt !== 2'd0 || b_other_cnt !== 2'd0) begin
      bad++;
      $display("FAIL sat_other_counts: one=%0d other=%0d, want 0 0", b_one_cnt, b_other_cnt);
    end
  endtask

  task automatic test_clear();
    int rc0 = rep_count;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL clear_idle: in_ready=%b, want 1", in_ready);
    end
    in_data = 32'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = '0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    drain();
    total++;
    if ({one_cnt, two_cnt, seq_cnt, other_cnt} !== '0 || rep_class !== 2'd0) begin
      bad++;
      $display("FAIL clear_state: counts=%h class=%0d, want 0 0",
               {one_cnt, two_cnt, seq_cnt, other_cnt}, rep_class);
    end
    total++;
    if (rep_count - rc0 != 1) begin
      bad++;
      $display("FAIL clear_pulse: got %0d pulses, want 1", rep_count - rc0);
    end
    send(32'd1);
    drain();
    total++;
    if (rep_class !== CLS_ONE || one_cnt !== 16'd1 || seq_cnt !== 16'd0) begin
      bad++;
      $display("FAIL clear_history: class=%0d one=%0d seq=%0d, want 1 1 0", rep_class, one_cnt, seq_cnt);
    end
  endtask

  task automatic test_reset_abort();
    int rc0 = rep_count;
    in_data = 32'd1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1 || rep_valid !== 1'b0) begin
      bad++;
      $display("FAIL abort_handshake: in_ready=%b rep_valid=%b, want 1 0", in_ready, rep_valid);
    end
    total++;
    if ({one_cnt, two_cnt, seq_cnt, other_cnt} !== '0) begin
      bad++;
      $display("FAIL abort_counts: %h, want 0", {one_cnt, two_cnt, seq_cnt, other_cnt});
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (rep_count - rc0 != 0 || one_cnt !== 16'd0) begin
      bad++;
      $display("FAIL abort_dropped: reports=%0d one=%0d, want 0 0", rep_count - rc0, one_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold_valid();
    test_saturation();
    test_clear();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
